encoder_4to2_rr: RTL and testbench

- Registered 4-to-2 request encoder; the inverse of the 2-to-4 register decoder.
- Takes up to four request lines (one per register/unit) and selects one of them.
- Presents the selected line's 2-bit index with a valid/ack handshake, plus a one-hot grant so requesters can see which one was taken.
- Sits in front of register-select logic in the Lab5 datapath where several sources compete for one regNo bus.

---
 rtl/encoder_4to2_rr.sv | 137 +++++++++++++
 tb/tb_encoder_4to2_rr.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/encoder_4to2_rr.sv
// Registered 4-to-2 request encoder with a valid/ack handshake, one-hot grant
// and a multi-request flag. RR_MODE=1 rotates priority; RR_MODE=0 is fixed (bit 0 highest).
module encoder_4to2_rr #(
  parameter bit RR_MODE = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic       ack,
  output logic       valid,
  output logic [1:0] regNo,
  output logic [3:0] grant,
  output logic       multi,
  output logic       dbg_state,
  output logic [1:0] dbg_ptr
);

  // Handshake: a selection is live while valid=1 and is held unchanged until
  // the consumer raises ack at a posedge; ack while valid=0 has no effect.
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic       valid_q, valid_d;
  logic [1:0] regno_q, regno_d;
  logic [3:0] grant_q, grant_d;
  logic       multi_q, multi_d;
  logic [3:0] masked;
  logic [1:0] ack_ptr;
  logic [1:0] pick_idle;
  logic [1:0] pick_next;

  // First set bit of v scanning upward from start, wrapping modulo 4.
  function automatic logic [1:0] sel(input logic [3:0] v, input logic [1:0] start);
    logic [1:0] idx;
    logic       found;
    sel   = start;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = start + k[1:0];
      if (!found && v[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
  endfunction

  function automatic logic many(input logic [3:0] v);
    many = (v & (v - 4'd1)) != 4'd0;
  endfunction

  function automatic logic [3:0] onehot(input logic [1:0] idx);
    onehot = 4'b0001 << idx;
  endfunction

  // On an ack the pointer moves past the granted index before the next scan.
  assign ack_ptr   = RR_MODE ? (regno_q + 2'd1) : 2'd0;
  assign masked    = req & ~grant_q;
  assign pick_idle = sel(req, RR_MODE ? ptr_q : 2'd0);
  assign pick_next = sel(masked, ack_ptr);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    valid_d = valid_q;
    regno_d = regno_q;
    grant_d = grant_q;
    multi_d = multi_q;
    case (state_q)
      IDLE: begin
        if (req != 4'd0) begin
          regno_d = pick_idle;
          grant_d = onehot(pick_idle);
          multi_d = many(req);
          valid_d = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (ack) begin
          ptr_d = ack_ptr;
          if (masked != 4'd0) begin
            regno_d = pick_next;
            grant_d = onehot(pick_next);
            multi_d = many(masked);
          end else begin
            // regNo deliberately keeps the last granted index.
            valid_d = 1'b0;
            grant_d = 4'd0;
            multi_d = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        grant_d = 4'd0;
        multi_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      valid_q <= 1'b0;
      regno_q <= 2'd0;
      grant_q <= 4'd0;
      multi_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
      regno_q <= regno_d;
      grant_q <= grant_d;
      multi_q <= multi_d;
    end
  end

  assign valid     = valid_q;
  assign regNo     = regno_q;
  assign grant     = grant_q;
  assign multi     = multi_q;
  assign dbg_state = state_q;
  assign dbg_ptr   = ptr_q;

  a_grant_onehot: assert property (@(posedge clk) disable iff (reset)
    valid_q |-> (grant_q == onehot(regno_q)));
  a_grant_idle: assert property (@(posedge clk) disable iff (reset)
    !valid_q |-> (grant_q == 4'd0));

endmodule

// File: tb/tb_encoder_4to2_rr.sv
// Bench for encoder_4to2_rr: a round-robin and a fixed-priority instance run
// side by side against a behavioural reference model.
module tb_encoder_4to2_rr;

  logic       clk;
  logic       reset;
  logic [3:0] req_rr, req_fp;
  logic       ack_rr, ack_fp;
  logic       valid_rr, valid_fp;
  logic [1:0] regno_rr, regno_fp;
  logic [3:0] grant_rr, grant_fp;
  logic       multi_rr, multi_fp;
  logic       st_rr, st_fp;
  logic [1:0] ptr_rr, ptr_fp;

  int checks   = 0;
  int failures = 0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  encoder_4to2_rr #(.RR_MODE(1'b1)) u_rr (
    .clk(clk), .reset(reset), .req(req_rr), .ack(ack_rr),
    .valid(valid_rr), .regNo(regno_rr), .grant(grant_rr), .multi(multi_rr),
    .dbg_state(st_rr), .dbg_ptr(ptr_rr)
  );

  encoder_4to2_rr #(.RR_MODE(1'b0)) u_fp (
    .clk(clk), .reset(reset), .req(req_fp), .ack(ack_fp),
    .valid(valid_fp), .regNo(regno_fp), .grant(grant_fp), .multi(multi_fp),
    .dbg_state(st_fp), .dbg_ptr(ptr_fp)
  );

  // ---------------- reference model (index 0 = fixed, 1 = round-robin) ----
  bit         m_busy [2];
  int         m_idx  [2];
  logic [3:0] m_grant[2];
  bit         m_multi[2];
  int         m_ptr  [2];

  function automatic int pick(input logic [3:0] v, input int start);
    for (int off = 0; off < 4; off++) begin
      int i;
      i = (start + off) % 4;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int n = 0; n < 2; n++) begin
      m_busy[n] = 0; m_idx[n] = 0; m_grant[n] = 4'd0; m_multi[n] = 0; m_ptr[n] = 0;
    end
  endtask

  task automatic model_grant(input int n, input logic [3:0] v);
    int i;
    i = pick(v, (n == 1) ? m_ptr[n] : 0);
    m_idx[n]   = i;
    m_grant[n] = 4'd0;
    m_grant[n][i] = 1'b1;
    m_multi[n] = ($countones(v) > 1);
    m_busy[n]  = 1;
  endtask

  task automatic model_step(input int n, input logic [3:0] r, input logic a);
    logic [3:0] rest;
    if (!m_busy[n]) begin
      if (r != 4'd0) model_grant(n, r);
    end else if (a) begin
      if (n == 1) m_ptr[n] = (m_idx[n] + 1) % 4;
      rest = r & ~m_grant[n];
      if (rest != 4'd0) model_grant(n, rest);
      else begin
        m_busy[n] = 0; m_grant[n] = 4'd0; m_multi[n] = 0;
      end
    end
  endtask

  function automatic logic [10:0] exp_b(input int n);
    logic [1:0] idx2, ptr2;
    idx2 = m_idx[n][1:0];
    ptr2 = m_ptr[n][1:0];
    return {m_busy[n], idx2, m_grant[n], m_multi[n], m_busy[n], ptr2};
  endfunction

  function automatic logic [10:0] act_b(input int n);
    if (n == 1) return {valid_rr, regno_rr, grant_rr, multi_rr, st_rr, ptr_rr};
    return {valid_fp, regno_fp, grant_fp, multi_fp, st_fp, ptr_fp};
  endfunction

  // ---------------- driver tasks ----------------
  // Called just after a posedge; inputs are already set for the coming edge.
  task automatic step();
    model_step(0, req_fp, ack_fp);
    model_step(1, req_rr, ack_rr);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req_rr = 4'd0; req_fp = 4'd0; ack_rr = 1'b0; ack_fp = 1'b0;
    reset = 1'b1;
    model_reset();
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    checks++;
    if (act_b(1) !== exp_b(1) || act_b(1) !== 11'd0) begin
      failures++; $display("FAIL reset_state_rr got=%h want=%h", act_b(1), exp_b(1));
    end
    checks++;
    if (act_b(0) !== 11'd0) begin
      failures++; $display("FAIL reset_state_fp got=%h want=000", act_b(0));
    end
  endtask

  task automatic test_reset_mid_busy();
    req_rr = 4'b0010;
    step();
    checks++;
    if (valid_rr !== 1'b1 || regno_rr !== 2'b01) begin
      failures++; $display("FAIL busy_before_reset valid=%b regNo=%b want 1/01", valid_rr, regno_rr);
    end
    #2 reset = 1'b1;
    model_reset();
    #1;
    checks++;
    if (act_b(1) !== 11'd0) begin
      failures++; $display("FAIL async_reset_clear got=%h want=000", act_b(1));
    end
    @(posedge clk); #1;
    reset  = 1'b0;
    req_rr = 4'd0;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (act_b(1) !== 11'd0) begin
        failures++; $display("FAIL post_reset_idle cyc=%0d got=%h want=000", c, act_b(1));
      end
    end
  endtask

  task automatic test_single_hold();
    do_reset();
    req_rr = 4'b0100;
    step();
    checks++;
    if ({valid_rr, regno_rr, grant_rr, multi_rr} !== {1'b1, 2'b10, 4'b0100, 1'b0}) begin
      failures++; $display("FAIL single_req got=%b%b%b%b want=1_10_0100_0",
                           valid_rr, regno_rr, grant_rr, multi_rr);
    end
    req_rr = 4'b0001;
    for (int c = 0; c < 5; c++) begin
      step();
      checks++;
      if (act_b(1) !== exp_b(1) || regno_rr !== 2'b10 || grant_rr !== 4'b0100) begin
        failures++; $display("FAIL hold_no_ack cyc=%0d got=%h want=%h", c, act_b(1), exp_b(1));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] seq [6];
    seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    do_reset();
    req_rr = 4'b1111;
    step();
    for (int c = 0; c < 6; c++) begin
      checks++;
      if (regno_rr !== seq[c] || valid_rr !== 1'b1 || multi_rr !== 1'b1 ||
          act_b(1) !== exp_b(1)) begin
        failures++; $display("FAIL rr_rotation cyc=%0d regNo=%0d valid=%b multi=%b want regNo=%0d",
                             c, regno_rr, valid_rr, multi_rr, seq[c]);
      end
      ack_rr = 1'b1;
      step();
    end
    ack_rr = 1'b0;
  endtask

  task automatic test_fixed_priority();
    do_reset();
    req_fp = 4'b1010;
    step();
    checks++;
    if (regno_fp !== 2'b01 || multi_fp !== 1'b1 || grant_fp !== 4'b0010) begin
      failures++; $display("FAIL fixed_first regNo=%b multi=%b grant=%b want 01/1/0010",
                           regno_fp, multi_fp, grant_fp);
    end
    ack_fp = 1'b1;
    step();
    checks++;
    if (regno_fp !== 2'b11 || grant_fp !== 4'b1000 || multi_fp !== 1'b0 || valid_fp !== 1'b1) begin
      failures++; $display("FAIL fixed_second regNo=%b grant=%b multi=%b want 11/1000/0",
                           regno_fp, grant_fp, multi_fp);
    end
    req_fp = 4'b1000;
    step();
    checks++;
    if (valid_fp !== 1'b0 || grant_fp !== 4'd0 || st_fp !== 1'b0 || ptr_fp !== 2'd0) begin
      failures++; $display("FAIL fixed_drain valid=%b grant=%b state=%b ptr=%0d want 0/0000/0/0",
                           valid_fp, grant_fp, st_fp, ptr_fp);
    end
    ack_fp = 1'b0; req_fp = 4'd0;
  endtask

  task automatic test_drain_reentry();
    do_reset();
    req_rr = 4'b1000;
    step();
    checks++;
    if (regno_rr !== 2'b11) begin
      failures++; $display("FAIL grant_idx3 regNo=%b want 11", regno_rr);
    end
    ack_rr = 1'b1;
    step();
    checks++;
    if (valid_rr !== 1'b0 || grant_rr !== 4'd0 || regno_rr !== 2'b11 || ptr_rr !== 2'd0) begin
      failures++; $display("FAIL mask_granted valid=%b grant=%b regNo=%b ptr=%0d want 0/0000/11/0",
                           valid_rr, grant_rr, regno_rr, ptr_rr);
    end
    ack_rr = 1'b0; req_rr = 4'b1001;
    step();
    checks++;
    if (regno_rr !== 2'b00 || multi_rr !== 1'b1 || valid_rr !== 1'b1) begin
      failures++; $display("FAIL reentry_wrap regNo=%b multi=%b valid=%b want 00/1/1",
                           regno_rr, multi_rr, valid_rr);
    end
  endtask

  task automatic test_ack_in_idle();
    do_reset();
    req_rr = 4'b0010;
    step();
    ack_rr = 1'b1; req_rr = 4'd0;
    step();
    for (int c = 0; c < 4; c++) begin
      step();
      checks++;
      if (valid_rr !== 1'b0 || ptr_rr !== 2'd2) begin
        failures++; $display("FAIL idle_ack cyc=%0d valid=%b ptr=%0d want 0/2", c, valid_rr, ptr_rr);
      end
    end
    ack_rr = 1'b0; req_rr = 4'b0011;
    step();
    checks++;
    if (regno_rr !== 2'b00 || act_b(1) !== exp_b(1)) begin
      failures++; $display("FAIL idle_ack_then_req regNo=%b want 00", regno_rr);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      req_rr = 4'($urandom_range(0, 15));
      req_fp = 4'($urandom_range(0, 15));
      ack_rr = ($urandom_range(0, 99) < 60);
      ack_fp = ($urandom_range(0, 99) < 60);
      if ($urandom_range(0, 7) == 0) begin
        req_rr = 4'd0; req_fp = 4'd0;
      end
      step();
      checks++;
      if (act_b(1) !== exp_b(1)) begin
        failures++; $display("FAIL random_rr cyc=%0d got=%h want=%h", c, act_b(1), exp_b(1));
      end
      checks++;
      if (act_b(0) !== exp_b(0)) begin
        failures++; $display("FAIL random_fp cyc=%0d got=%h want=%h", c, act_b(0), exp_b(0));
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset = 1'b1;
    req_rr = 4'd0; req_fp = 4'd0; ack_rr = 1'b0; ack_fp = 1'b0;
    model_reset();
    #1;
    test_reset();
    test_reset_mid_busy();
    test_single_hold();
    test_back_to_back();
    test_fixed_priority();
    test_drain_reentry();
    test_ack_in_idle();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
